ram_sp_param: RTL
=================

# ram_sp_param

Parametrised single-port synchronous RAM, the next generation of the team's fixed 16x8 RAM. Adds configurable width and depth, a pipelined read path with a read-valid strobe, and a hardware clear engine that zeroes the array after reset and on request. Sits beside datapath blocks as local scratch storage and keeps the established chip-select / write-enable / output-enable port style.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of words (>=2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- RD_LAT, 1, read latency in cycles (legal values: 1 or 2)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cs  input  1  chip select; no access when low
- w_en  input  1  1 = write, 0 = read (qualified by cs)
- op_en  input  1  output enable for data_out
- addr_in  input  ADDR_W  word address
- data_in  input  DATA_W  write data
- clr_req  input  1  request a full-array clear (level sampled in IDLE)
- data_out  output  DATA_W  read data
- rd_valid  output  1  one-cycle strobe: data_out carries a read result
- busy  output  1  clear sweep in progress; accesses ignored
- par_inj  input  1  parity error injection (only with RAM_PARITY_EN)
- par_err  output  1  parity mismatch on current read (only with RAM_PARITY_EN)

## Operation
- FSM states: INIT, IDLE, CLR.
- Reset (reset_n=0): FSM -> INIT, sweep counter = 0, read pipeline cleared. Outputs: data_out=0, rd_valid=0, busy=1, par_err=0.
- INIT/CLR: write 0 (and even parity 0) to address = sweep counter each cycle, counter +1; after writing DEPTH-1 -> IDLE. Sweep takes exactly DEPTH cycles. busy=1 throughout.
- While busy: cs, w_en, addr_in, data_in, clr_req ignored; no read issued, rd_valid stays 0.
- IDLE, clr_req=1: -> CLR, counter = 0. If cs is also high that cycle, clear wins; access dropped.
- IDLE write: cs=1, w_en=1 -> mem[addr_in] <= data_in.
- IDLE read: cs=1, w_en=0 -> read issued; result enters read pipeline.
- Address >= DEPTH: write discarded; read still issues rd_valid with data 0.
- data_out = op_en ? read-pipeline data : 0. rd_valid is independent of op_en.
- data_out holds the last read result (subject to op_en) until the next read completes; cleared only by reset.
- Reset asserted mid-sweep or mid-read: immediate return to INIT, pipeline flushed, sweep restarts from 0.

## Timing
- Write: committed at the edge where cs=1, w_en=1 is sampled.
- Read issued at edge N: data_out updated and rd_valid=1 during cycle after edge N+RD_LAT-1 (RD_LAT=1: visible right after edge N; RD_LAT=2: one cycle later).
- Back-to-back reads: one result per cycle, rd_valid stays high continuously.
- Write at edge N, read same address at edge N+1: returns new data.
- First access accepted: edge after busy falls; busy falls DEPTH cycles after reset_n rises (DEPTH+1 in first edge counting).
- A read in flight when clr_req enters CLR completes normally with pre-clear data.

## Configuration
- RAM_PARITY_EN defined: each word stores one extra even-parity bit computed from data_in on write (inverted when par_inj=1 during the write). Each read recomputes parity; par_err=1 aligned with rd_valid when mismatched, else 0. Clear sweep writes correct parity. Ports par_inj and par_err exist.
- RAM_PARITY_EN undefined: no parity storage, par_inj and par_err ports absent; all other behaviour identical.

## Test plan
- Reset release, DEPTH=16: busy=1 for 16 cycles then 0; read of every address returns 0x00 with rd_valid pulse each.
- Write 0xA5 to addr 3, read addr 3 next cycle, op_en=1: data_out=0xA5 with rd_valid after RD_LAT; repeat op_en=0: data_out=0x00, rd_valid still 1.
- RD_LAT=2, back-to-back reads of addr 0..3 holding 0x11,0x22,0x33,0x44: rd_valid high 4 consecutive cycles, data in order, starting 2 cycles after first issue.
- Write 0x5A to addr 7, assert clr_req with simultaneous write 0xFF to addr 8: busy 16 cycles, then addr 7 and 8 read 0x00.
- reset_n pulsed low at sweep count 5: busy stays high, sweep restarts, busy falls 16 cycles after release; DEPTH=12, write addr 13 ignored, read returns 0.
- RAM_PARITY_EN: write 0x3C with par_inj=1, read: par_err=1 with rd_valid; write 0x3C with par_inj=0, read: par_err=0.

Source files
------------

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with pipelined read, read-valid strobe
// and a clear engine that zeroes the array after reset and on request. Optional parity: RAM_PARITY_EN.
module ram_sp_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              w_en,
  input  logic              op_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_req,
`ifdef RAM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sweep, wr_en, rd_issue, in_range;
  logic [WORD_W-1:0]   wr_word, rd_word;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic                vld_p1_q;
  logic [DATA_W-1:0]   dat_p1_q;
  logic                vld_lst;
  logic [DATA_W-1:0]   dat_lst;
`ifdef RAM_PARITY_EN
  logic                perr_p1_q;
  logic                perr_lst;
`endif

  assign in_range = ({1'b0, addr_in} < DEPTH_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear has priority over any access sampled in the same IDLE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep    = 1'b0;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      ST_INIT, ST_CLR: begin
        sweep = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLR;
          cnt_d   = '0;
        end else if (cs) begin
          wr_en    = w_en & in_range;
          rd_issue = ~w_en;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

`ifdef RAM_PARITY_EN
  assign wr_word = {(^data_in) ^ par_inj, data_in};
`else
  assign wr_word = data_in;
`endif

  // A zero word already carries correct even parity.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[addr_in] <= wr_word;
    end
  end

  assign rd_word = mem_q[addr_in];

  // ---- read stage 1: array access, out-of-range reads return zero ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q  <= 1'b0;
      dat_p1_q  <= '0;
`ifdef RAM_PARITY_EN
      perr_p1_q <= 1'b0;
`endif
    end else begin
      vld_p1_q <= rd_issue;
      if (rd_issue) begin
        dat_p1_q  <= in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef RAM_PARITY_EN
        perr_p1_q <= in_range & (^rd_word);
`endif
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p2_q;
      logic [DATA_W-1:0] dat_p2_q;
`ifdef RAM_PARITY_EN
      logic              perr_p2_q;
`endif
      // ---- read stage 2: extra register, holds last result between reads ----
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p2_q  <= 1'b0;
          dat_p2_q  <= '0;
`ifdef RAM_PARITY_EN
          perr_p2_q <= 1'b0;
`endif
        end else begin
          vld_p2_q <= vld_p1_q;
          if (vld_p1_q) begin
            dat_p2_q  <= dat_p1_q;
`ifdef RAM_PARITY_EN
            perr_p2_q <= perr_p1_q;
`endif
          end
        end
      end
      assign vld_lst  = vld_p2_q;
      assign dat_lst  = dat_p2_q;
`ifdef RAM_PARITY_EN
      assign perr_lst = perr_p2_q;
`endif
    end else begin : g_lat1
      assign vld_lst  = vld_p1_q;
      assign dat_lst  = dat_p1_q;
`ifdef RAM_PARITY_EN
      assign perr_lst = perr_p1_q;
`endif
    end
  endgenerate

  assign rd_valid = vld_lst;
  assign data_out = op_en ? dat_lst : '0;
`ifdef RAM_PARITY_EN
  assign par_err  = vld_lst & perr_lst;
`endif

endmodule
